// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// presents {instruction, PC, PC+4, valid} to the IF/ID pipeline registers.
// Copes with a multi-cycle memory, downstream stalls and EX redirects.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busywait,
    output logic [31:0] instruction_out,
    output logic [31:0] PC_out,
    output logic [31:0] PC4_out,
    output logic        inst_valid
);

    // S_HOLD: a completed fetch is parked in r_hold_buf while IF/ID is stalled.
    // S_FLUSH: a redirect arrived mid-read; the stale read must finish first.
    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_flush_addr;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_hold_buf;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc4_out;
    logic        r_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_flush_addr_nxt;
    logic [31:0] w_redirect_pc_nxt;
    logic [31:0] w_hold_buf_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_out_nxt;
    logic [31:0] w_pc4_out_nxt;
    logic        w_valid_nxt;
    logic        w_done;
    logic [31:0] w_pc_plus4;

    // Memory interface depends on state only, so the address is stable
    // for the whole cycle and held across an outstanding stale read.
    assign imem_read  = (r_state != S_HOLD);
    assign imem_addr  = (r_state == S_FLUSH) ? r_flush_addr : r_pc;
    assign w_done     = imem_read & ~imem_busywait;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign instruction_out = r_instr;
    assign PC_out          = r_pc_out;
    assign PC4_out         = r_pc4_out;
    assign inst_valid      = r_valid;

    // State and datapath registers, asynchronously reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_VECTOR;
            r_flush_addr  <= '0;
            r_redirect_pc <= '0;
            r_hold_buf    <= '0;
            r_instr       <= NOP_INST;
            r_pc_out      <= '0;
            r_pc4_out     <= '0;
            r_valid       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_flush_addr  <= w_flush_addr_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_hold_buf    <= w_hold_buf_nxt;
            r_instr       <= w_instr_nxt;
            r_pc_out      <= w_pc_out_nxt;
            r_pc4_out     <= w_pc4_out_nxt;
            r_valid       <= w_valid_nxt;
        end
    end

    // Next-state and next-output logic; priority is redirect > stall > completion.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_flush_addr_nxt  = r_flush_addr;
        w_redirect_pc_nxt = r_redirect_pc;
        w_hold_buf_nxt    = r_hold_buf;
        w_instr_nxt       = r_instr;
        w_pc_out_nxt      = r_pc_out;
        w_pc4_out_nxt     = r_pc4_out;
        w_valid_nxt       = r_valid;

        case (r_state)
            S_FETCH: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_INST;
                    if (!w_done) begin
                        w_redirect_pc_nxt = branch_target;
                        w_flush_addr_nxt  = r_pc;
                        w_state_nxt       = S_FLUSH;
                    end
                end else if (stall) begin
                    if (w_done) begin
                        w_hold_buf_nxt = imem_rdata;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (w_done) begin
                    w_instr_nxt   = imem_rdata;
                    w_pc_out_nxt  = r_pc;
                    w_pc4_out_nxt = w_pc_plus4;
                    w_valid_nxt   = 1'b1;
                    w_pc_nxt      = w_pc_plus4;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_INST;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_INST;
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_instr_nxt   = r_hold_buf;
                    w_pc_out_nxt  = r_pc;
                    w_pc4_out_nxt = w_pc_plus4;
                    w_valid_nxt   = 1'b1;
                    w_pc_nxt      = w_pc_plus4;
                    w_state_nxt   = S_FETCH;
                end
            end
            S_FLUSH: begin
                // Outputs already carry a bubble; the returning data is discarded.
                if (branch_taken) begin
                    w_redirect_pc_nxt = branch_target;
                end
                if (w_done) begin
                    w_pc_nxt    = branch_taken ? branch_target : r_redirect_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized stall / redirect / wait-state / reset traffic, compared every
// cycle against a transaction-level reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busywait = 1'b0;
    logic [31:0] instruction_out;
    logic [31:0] PC_out;
    logic [31:0] PC4_out;
    logic        inst_valid;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .RESET_VECTOR(RV),
        .NOP_INST    (NOP)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_read      (imem_read),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_busywait  (imem_busywait),
        .instruction_out(instruction_out),
        .PC_out         (PC_out),
        .PC4_out        (PC4_out),
        .inst_valid     (inst_valid)
    );

    always #5 CLK = ~CLK;

    // Instruction memory content: a fixed scramble of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + {a[15:0], a[31:16]};
    endfunction

    assign imem_rdata = mem_fn(imem_addr);

    // Reference model: program-order view of the fetch stage.
    logic [31:0] m_pc;
    logic [31:0] held_q[$];     // at most one fetched-but-stalled instruction
    bit          m_stale;       // a discarded read is still outstanding
    logic [31:0] m_stale_addr;
    logic [31:0] m_dest;        // where fetching resumes after the stale read
    logic [31:0] m_instr, m_pcout, m_pc4;
    bit          m_valid;

    function automatic void model_reset();
        m_pc = RV;
        held_q.delete();
        m_stale = 0;
        m_stale_addr = '0;
        m_dest = '0;
        m_instr = NOP;
        m_pcout = '0;
        m_pc4 = '0;
        m_valid = 0;
    endfunction

    function automatic void deliver(input logic [31:0] a, input logic [31:0] d);
        m_valid = 1;
        m_instr = d;
        m_pcout = a;
        m_pc4   = a + 32'd4;
        m_pc    = a + 32'd4;
    endfunction

    function automatic void squash(input logic [31:0] t);
        m_pc    = t;
        m_valid = 0;
        m_instr = NOP;
    endfunction

    function automatic void model_step(input bit st, input bit br, input logic [31:0] tgt, input bit bw);
        bit          reading;
        logic [31:0] addr;
        bit          done;
        reading = (held_q.size() == 0);
        addr    = m_stale ? m_stale_addr : m_pc;
        done    = reading && !bw;
        if (m_stale) begin
            if (br) m_dest = tgt;
            if (done) begin
                m_pc    = m_dest;
                m_stale = 0;
            end
        end else if (held_q.size() != 0) begin
            if (br) begin
                held_q.delete();
                squash(tgt);
            end else if (!st) begin
                deliver(m_pc, held_q.pop_front());
            end
        end else if (br) begin
            squash(tgt);
            if (!done) begin
                m_stale      = 1;
                m_stale_addr = addr;
                m_dest       = tgt;
            end
        end else if (done && !st) begin
            deliver(m_pc, mem_fn(m_pc));
        end else if (done) begin
            held_q.push_back(mem_fn(m_pc));
        end else if (!st) begin
            m_valid = 0;
            m_instr = NOP;
        end
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("imem_read", {31'd0, imem_read}, {31'd0, held_q.size() == 0});
        check_val("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        check_val("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        check_val("instruction_out", instruction_out, m_instr);
        check_val("PC_out", PC_out, m_pcout);
        check_val("PC4_out", PC4_out, m_pc4);
    endtask

    // Called at a negedge: drive one cycle of inputs, advance model, check after posedge.
    task automatic step(input bit st, input bit br, input logic [31:0] tgt, input bit bw);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        imem_busywait = bw;
        model_step(st, br, tgt, bw);
        @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
    endtask

    // Asynchronous reset applied mid-cycle; checked immediately and after an edge.
    task automatic do_reset();
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge CLK);
        check_all();
        RESET = 1'b0;

        // Streaming at one instruction per cycle: 0, 4
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        // Stall while @4 is shown and @8 returns, then release
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);
        // Two wait states at 12, then completion
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        // Redirect to 0x20 with 0-wait memory, then redirect to 0x100 mid-read
        step(0, 1, 32'h20, 0);
        step(0, 1, 32'h100, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        // Newest redirect wins during a stale read
        step(0, 1, 32'h300, 1);
        step(0, 1, 32'h340, 1);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        // Redirect in S_HOLD, and redirect together with stall in S_FETCH
        step(1, 0, '0, 0);
        step(1, 1, 32'h200, 0);
        step(0, 0, '0, 0);
        step(1, 1, 32'h400, 0);
        step(0, 0, '0, 0);
        // Wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        // Reset in the middle of a wait-stated read
        step(0, 0, '0, 1);
        do_reset();
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit          st, br, bw;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 9) == 0);
            bw  = ($urandom_range(0, 9) < 4);
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(st, br, tgt, bw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
